// File: rtl/sprite_compositor.sv
// sprite_compositor
//   Final stage after the per-sprite renderers. Picks the winning layer per
//   pixel (sprite 0 = player, highest priority; background when nothing
//   hits; black outside active video) and registers the RGB for the video
//   encoder. Also gathers player-vs-sprite overlaps over a frame and reports
//   them once per frame, triggered by the v_sync rising edge.
//
// Ports
//   i_clk, i_rst          pixel clock, asynchronous active-high reset
//   i_de, i_v_sync        active-video qualifier, vertical sync level
//   i_bg_rgb              background pixel {R,G,B}
//   i_sprite_rgb          sprite k pixel at [24k+23:24k]
//   i_sprite_hit          sprite k opaque at this position
//   o_red/green/blue      composited colour, 2 cycles after the inputs
//   o_de                  i_de delayed to match the colour
//   o_collision           bit k-1: player overlapped sprite k last frame
//   o_collision_valid     one-cycle pulse when o_collision updates
//   o_frame_count         completed frames since reset (wraps)
//
// Build option
//   SPRITE_COMPOSITOR_HITBOX_DEBUG_EN : paint colliding pixels pure red.
module sprite_compositor #(
   parameter int NUM_SPRITES = 4,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_de,
   input  logic                       i_v_sync,
   input  logic [23:0]                i_bg_rgb,
   input  logic [24*NUM_SPRITES-1:0]  i_sprite_rgb,
   input  logic [NUM_SPRITES-1:0]     i_sprite_hit,
   output logic [7:0]                 o_red,
   output logic [7:0]                 o_green,
   output logic [7:0]                 o_blue,
   output logic                       o_de,
   output logic [NUM_SPRITES-2:0]     o_collision,
   output logic                       o_collision_valid,
   output logic [FRAME_CNT_W-1:0]     o_frame_count
);

   localparam int STAGES = 2;
   localparam int NC     = NUM_SPRITES - 1;

   typedef struct packed {
      logic                               vs;
      logic [23:0]                        bg;
      logic [NUM_SPRITES-1:0]             hit;
      logic [NUM_SPRITES-1:0][23:0]       rgb;
   } s1_t;

   typedef enum logic [1:0] {S_SYNC, S_ACTIVE, S_REPORT} state_t;

   // de travels down its own shift register; bit 1 = stage 1, bit 2 = o_de
   logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
   s1_t               s1_q, s1_d;
   logic [23:0]       rgb_q, rgb_d;
   logic              vs_prev_q, vs_prev_d;
   state_t            state_q, state_d;
   logic [NC-1:0]     acc_q, acc_d;
   logic [NC-1:0]     hold_q, hold_d;
   logic [NC-1:0]     coll_q, coll_d;
   logic              valid_q, valid_d;
   logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

   logic              de1;
   logic              vs_rise;
   logic [NC-1:0]     col;
   logic [23:0]       sel;

   assign de1     = vld_pipe_q[1];
   assign vs_rise = s1_q.vs & ~vs_prev_q;

   // stage 1 capture
   always_comb begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], i_de};
      s1_d.vs    = i_v_sync;
      s1_d.bg    = i_bg_rgb;
      s1_d.hit   = i_sprite_hit;
      s1_d.rgb   = i_sprite_rgb;
      vs_prev_d  = s1_q.vs;
   end

   // player overlap term, qualified by active video
   always_comb begin
      col = '0;
      for (int k = 1; k < NUM_SPRITES; k++)
         col[k-1] = de1 & s1_q.hit[0] & s1_q.hit[k];
   end

   // priority: scan from the lowest priority up so the lowest index wins
   always_comb begin
      sel = s1_q.bg;
      for (int k = NUM_SPRITES-1; k >= 0; k--)
         if (s1_q.hit[k]) sel = s1_q.rgb[k];
      if (!de1) sel = 24'h000000;
`ifdef SPRITE_COMPOSITOR_HITBOX_DEBUG_EN
      if (|col) sel = 24'hFF0000;
`endif
      rgb_d = sel;
   end

   // Frame collision FSM. On the edge cycle the running accumulator is frozen
   // and that cycle's term is parked in hold_q, so a coincident overlap lands
   // in the next frame. The report registers load in S_REPORT.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      hold_d  = hold_q;
      coll_d  = coll_q;
      valid_d = 1'b0;
      fcnt_d  = fcnt_q;
      case (state_q)
         S_SYNC: begin
            acc_d = '0;
            if (vs_rise) state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (vs_rise) begin
               hold_d  = col;
               state_d = S_REPORT;
            end else begin
               acc_d = acc_q | col;
            end
         end
         S_REPORT: begin
            coll_d  = acc_q;
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + FRAME_CNT_W'(1);
            acc_d   = hold_q | col;
            state_d = S_ACTIVE;
         end
         default: state_d = S_SYNC;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_pipe_q <= '0;
         s1_q       <= '0;
         rgb_q      <= '0;
         vs_prev_q  <= 1'b0;
         state_q    <= S_SYNC;
         acc_q      <= '0;
         hold_q     <= '0;
         coll_q     <= '0;
         valid_q    <= 1'b0;
         fcnt_q     <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         s1_q       <= s1_d;
         rgb_q      <= rgb_d;
         vs_prev_q  <= vs_prev_d;
         state_q    <= state_d;
         acc_q      <= acc_d;
         hold_q     <= hold_d;
         coll_q     <= coll_d;
         valid_q    <= valid_d;
         fcnt_q     <= fcnt_d;
      end
   end

   assign o_red             = rgb_q[23:16];
   assign o_green           = rgb_q[15:8];
   assign o_blue            = rgb_q[7:0];
   assign o_de              = vld_pipe_q[STAGES];
   assign o_collision       = coll_q;
   assign o_collision_valid = valid_q;
   assign o_frame_count     = fcnt_q;

endmodule
